irq_dispatch: RTL and testbench

Parametrised interrupt dispatcher for the system controller. It accepts NUM_IRQ interrupt lines with per-line enable mask and per-line edge/level trigger mode, and selects the highest-priority pending line. It then fetches that line's handler address from a computed interrupt-table entry over the memory request/data-phase handshake. Finally it flushes the pipeline, redirects fetch, and holds a service window with decode until decode signals end of interrupt.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_pri_sel.sv | 24 ++
 rtl/irq_dispatch.sv | 138 +++++++++++++
 tb/tb_irq_dispatch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_pkg : dispatcher FSM encoding and constant helpers  (rev 1.0)
// ------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_SERVICE = 3'd4
  } irq_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int irq_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit irq_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_pri_sel.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_pri_sel : lowest-index-first priority selector  (rev 1.0)
// ------------------------------------------------------------------
module irq_pri_sel #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scanning downward lets the lowest set index be the last write.
  always_comb begin
    valid_o = |eligible_i;
    id_o    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) id_o = ID_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_dispatch.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_dispatch : pending/priority, table fetch, flush and service  (rev 1.0)
// ------------------------------------------------------------------
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int                  NUM_IRQ    = 8,
  parameter int                  ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]   IDT_BASE   = 'h4000,
  parameter int                  IDT_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0]  TRIG_LEVEL = '0,
  parameter int                  ID_W       = irq_clog2(NUM_IRQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  int_vec,
  input  logic [NUM_IRQ-1:0]  int_mask,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_address,
  input  logic                mem_dp_valid,
  output logic                mem_dp_ready,
  input  logic [ADDR_W-1:0]   mem_dp_read_data,
  output logic                flush_pipe,
  output logic                fetch_load,
  output logic [ADDR_W-1:0]   fetch_load_address,
  output logic                decode_start_int,
  input  logic                decode_end_int,
  output logic                int_active,
  output logic [ID_W-1:0]     int_id,
  output logic [NUM_IRQ-1:0]  int_pending
);

  irq_state_e           state_q, state_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   int_vec_q;
  logic [ID_W-1:0]      int_id_q, int_id_d;
  logic [ADDR_W-1:0]    handler_q, handler_d;

  logic [NUM_IRQ-1:0]   eligible;
  logic                 sel_valid;
  logic [ID_W-1:0]      sel_id;
  logic [NUM_IRQ-1:0]   edge_set;
  logic [NUM_IRQ-1:0]   edge_clr;
  logic [NUM_IRQ-1:0]   edge_next;
  logic [ADDR_W-1:0]    entry_off;
  logic [ADDR_W-1:0]    entry_addr;

  assign eligible = pending_q & int_mask;

  irq_pri_sel #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_pri_sel (
    .eligible_i (eligible),
    .valid_o    (sel_valid),
    .id_o       (sel_id)
  );

  // Edge lines latch regardless of mask; a new edge beats the flush-cycle clear.
  assign edge_set  = int_vec & ~int_vec_q;
  assign edge_clr  = (state_q == ST_FLUSH) ? (NUM_IRQ'(1) << int_id_q) : '0;
  assign edge_next = (pending_q & ~edge_clr) | edge_set;
  assign pending_d = (TRIG_LEVEL & int_vec) | (~TRIG_LEVEL & edge_next);

  assign int_id_d  = (state_q == ST_IDLE && sel_valid) ? sel_id : int_id_q;
  assign handler_d = (state_q == ST_WAIT && mem_dp_valid) ? mem_dp_read_data : handler_q;

  generate
    if (irq_is_pow2(IDT_STRIDE)) begin : g_stride_shift
      localparam int STRIDE_SH = irq_clog2(IDT_STRIDE);
      assign entry_off = ADDR_W'(int_id_q) << STRIDE_SH;
    end else begin : g_stride_mul
      assign entry_off = ADDR_W'(int_id_q) * ADDR_W'(IDT_STRIDE);
    end
  endgenerate

  assign entry_addr = IDT_BASE + entry_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      int_vec_q <= '0;
      int_id_q  <= '0;
      handler_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_vec_q <= int_vec;
      int_id_q  <= int_id_d;
      handler_q <= handler_d;
    end
  end

  // Every output decodes registered state only; no input reaches an output directly.
  always_comb begin
    state_d          = state_q;
    mem_valid        = 1'b0;
    mem_address      = '0;
    mem_dp_ready     = 1'b0;
    flush_pipe       = 1'b0;
    fetch_load       = 1'b0;
    decode_start_int = 1'b0;
    int_active       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_valid   = 1'b1;
        mem_address = entry_addr;
        if (mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mem_dp_ready = 1'b1;
        if (mem_dp_valid) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_pipe = 1'b1;
        fetch_load = 1'b1;
        state_d    = ST_SERVICE;
      end
      ST_SERVICE: begin
        decode_start_int = 1'b1;
        if (decode_end_int) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fetch_load_address = handler_q;
  assign int_id             = int_id_q;
  assign int_pending        = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_irq_dispatch : directed bench for irq_dispatch, line 0 level-triggered  (rev 1.0)
// ------------------------------------------------------------------
module tb_irq_dispatch;

  logic        clk;
  logic        reset;
  logic [7:0]  int_vec;
  logic [7:0]  int_mask;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic        mem_dp_valid;
  logic        mem_dp_ready;
  logic [31:0] mem_dp_read_data;
  logic        flush_pipe;
  logic        fetch_load;
  logic [31:0] fetch_load_address;
  logic        decode_start_int;
  logic        decode_end_int;
  logic        int_active;
  logic [2:0]  int_id;
  logic [7:0]  int_pending;

  int vectors;
  int miscompares;

  irq_dispatch #(
    .NUM_IRQ    (8),
    .ADDR_W     (32),
    .IDT_BASE   (32'h4000),
    .IDT_STRIDE (4),
    .TRIG_LEVEL (8'h01)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .int_vec            (int_vec),
    .int_mask           (int_mask),
    .mem_valid          (mem_valid),
    .mem_ready          (mem_ready),
    .mem_address        (mem_address),
    .mem_dp_valid       (mem_dp_valid),
    .mem_dp_ready       (mem_dp_ready),
    .mem_dp_read_data   (mem_dp_read_data),
    .flush_pipe         (flush_pipe),
    .fetch_load         (fetch_load),
    .fetch_load_address (fetch_load_address),
    .decode_start_int   (decode_start_int),
    .decode_end_int     (decode_end_int),
    .int_active         (int_active),
    .int_id             (int_id),
    .int_pending        (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle into REQ with mem_ready and mem_dp_valid both high.
  task automatic run_service(input logic [31:0] data, input logic [7:0] exp_pend);
    mem_dp_read_data = data;
    step();
    chk("wait_dp_ready", 32'(mem_dp_ready), 32'd1);
    step();
    chk("flush_pipe", 32'(flush_pipe), 32'd1);
    chk("flush_fetch_load", 32'(fetch_load), 32'd1);
    chk("flush_target", fetch_load_address, data);
    step();
    chk("svc_start", 32'(decode_start_int), 32'd1);
    chk("svc_no_fetch", 32'(fetch_load), 32'd0);
    chk("svc_pending", 32'(int_pending), 32'(exp_pend));
    decode_end_int = 1'b1;
    step();
    decode_end_int = 1'b0;
    chk("idle_after_eoi", 32'(int_active), 32'd0);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    int_vec          = 8'h00;
    int_mask         = 8'hFF;
    mem_ready        = 1'b1;
    mem_dp_valid     = 1'b1;
    mem_dp_read_data = 32'h0;
    decode_end_int   = 1'b0;

    step();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_dp_ready", 32'(mem_dp_ready), 32'd0);
    chk("rst_flush", 32'(flush_pipe), 32'd0);
    chk("rst_fetch_load", 32'(fetch_load), 32'd0);
    chk("rst_fla", fetch_load_address, 32'd0);
    chk("rst_dsi", 32'(decode_start_int), 32'd0);
    chk("rst_active", 32'(int_active), 32'd0);
    chk("rst_id", 32'(int_id), 32'd0);
    chk("rst_pending", 32'(int_pending), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Single edge pulse on line 3.
    int_vec = 8'h08;
    step();
    chk("l3_pending", 32'(int_pending), 32'h08);
    chk("l3_not_active", 32'(int_active), 32'd0);
    int_vec = 8'h00;
    step();
    chk("l3_req", 32'(mem_valid), 32'd1);
    chk("l3_addr", mem_address, 32'h400C);
    chk("l3_id", 32'(int_id), 32'd3);
    run_service(32'h0000_1200, 8'h00);

    // Lines 5 and 2 together: 2 first, then 5 after one IDLE cycle.
    int_vec = 8'h24;
    step();
    chk("l25_pending", 32'(int_pending), 32'h24);
    int_vec = 8'h00;
    step();
    chk("l2_id", 32'(int_id), 32'd2);
    chk("l2_addr", mem_address, 32'h4008);
    run_service(32'h0000_2200, 8'h20);
    step();
    chk("l5_req", 32'(mem_valid), 32'd1);
    chk("l5_id", 32'(int_id), 32'd5);
    chk("l5_addr", mem_address, 32'h4014);
    run_service(32'h0000_5500, 8'h00);

    // Masked line 1 latches, dispatches one cycle after unmask.
    int_mask = 8'hFD;
    int_vec  = 8'h02;
    step();
    int_vec = 8'h00;
    for (int k = 0; k < 10; k++) step();
    chk("l1_masked_idle", 32'(int_active), 32'd0);
    chk("l1_masked_pending", 32'(int_pending), 32'h02);
    int_mask = 8'hFF;
    step();
    chk("l1_req", 32'(mem_valid), 32'd1);
    chk("l1_addr", mem_address, 32'h4004);
    run_service(32'h0000_1111, 8'h00);

    // Stalled handshake on line 4 with a spurious early data beat.
    mem_ready    = 1'b0;
    mem_dp_valid = 1'b0;
    int_vec      = 8'h10;
    step();
    int_vec = 8'h00;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_mem_valid", 32'(mem_valid), 32'd1);
      chk("stall_mem_addr", mem_address, 32'h4010);
      mem_dp_valid     = (k == 2);
      mem_dp_read_data = 32'hDEAD_0000;
      if (k == 4) begin
        mem_ready    = 1'b1;
        mem_dp_valid = 1'b0;
      end
      step();
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("dpwait_ready", 32'(mem_dp_ready), 32'd1);
      chk("dpwait_no_fetch", 32'(fetch_load), 32'd0);
      chk("dpwait_no_req", 32'(mem_valid), 32'd0);
      if (k == 2) begin
        mem_dp_valid     = 1'b1;
        mem_dp_read_data = 32'h0000_4444;
      end
      step();
    end
    chk("stall_fetch_load", 32'(fetch_load), 32'd1);
    chk("stall_target", fetch_load_address, 32'h0000_4444);
    mem_dp_valid = 1'b0;
    step();
    chk("stall_svc_no_fetch", 32'(fetch_load), 32'd0);
    chk("stall_svc_dsi", 32'(decode_start_int), 32'd1);
    decode_end_int = 1'b1;
    step();
    decode_end_int = 1'b0;
    chk("stall_idle", 32'(int_active), 32'd0);
    chk("stall_idle_no_fetch", 32'(fetch_load), 32'd0);
    mem_ready    = 1'b1;
    mem_dp_valid = 1'b1;

    // Level line 0: held through EOI re-dispatches, dropped before EOI does not.
    int_vec = 8'h01;
    step();
    chk("lvl_pending", 32'(int_pending), 32'h01);
    step();
    chk("lvl_id", 32'(int_id), 32'd0);
    chk("lvl_addr", mem_address, 32'h4000);
    run_service(32'h0000_0A00, 8'h01);
    chk("lvl_still_pending", 32'(int_pending), 32'h01);
    step();
    chk("lvl_redispatch", 32'(mem_valid), 32'd1);
    chk("lvl_redispatch_id", 32'(int_id), 32'd0);
    step();
    step();
    chk("lvl2_fetch_load", 32'(fetch_load), 32'd1);
    chk("lvl2_target", fetch_load_address, 32'h0000_0A00);
    step();
    chk("lvl2_dsi", 32'(decode_start_int), 32'd1);
    int_vec = 8'h00;
    step();
    chk("lvl2_dsi_hold", 32'(decode_start_int), 32'd1);
    chk("lvl2_pending_drop", 32'(int_pending), 32'h00);
    decode_end_int = 1'b1;
    step();
    decode_end_int = 1'b0;
    chk("lvl2_idle", 32'(int_active), 32'd0);
    step();
    chk("lvl2_stay_idle_a", 32'(int_active), 32'd0);
    step();
    chk("lvl2_stay_idle_b", 32'(int_active), 32'd0);

    // Asynchronous reset while waiting for read data on line 6.
    mem_dp_valid = 1'b0;
    int_vec      = 8'h40;
    step();
    int_vec = 8'h00;
    step();
    chk("l6_id", 32'(int_id), 32'd6);
    chk("l6_addr", mem_address, 32'h4018);
    step();
    chk("l6_wait", 32'(mem_dp_ready), 32'd1);
    chk("l6_wait_pending", 32'(int_pending), 32'h40);
    reset = 1'b1;
    #1;
    chk("arst_active", 32'(int_active), 32'd0);
    chk("arst_dp_ready", 32'(mem_dp_ready), 32'd0);
    chk("arst_pending", 32'(int_pending), 32'd0);
    chk("arst_id", 32'(int_id), 32'd0);
    chk("arst_fla", fetch_load_address, 32'd0);
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    mem_dp_valid     = 1'b1;
    mem_dp_read_data = 32'h0000_7777;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_no_fetch", 32'(fetch_load), 32'd0);
      chk("post_rst_idle", 32'(int_active), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
